// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam int          ENTRY_W = 64;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request outstanding, data is kept on ack
        S_DROP = 2'd1,   // request outstanding, data is thrown away on ack
        S_FULL = 2'd2    // buffer full, no request issued
    } state_t;

    // One buffered fetch: PC+4 of the instruction and the instruction word.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc+4, instruction} entries.
// Latency: a push is visible at o_head the cycle after it is written into an empty FIFO.
// Backpressure: push is ignored only when full without a pop; flush empties and wins over push/pop.
// Ports: clk, rst (sync, active high), i_push/i_push_dat, i_pop, i_flush, o_count, o_head.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A pop frees the slot the same cycle, so push is accepted even when full.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + AW'(1);
            if (w_do_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: the count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr] <= i_push_dat;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, runs a req/ack handshake to instruction memory
// and buffers words for decode. Latency: ack in N -> word at id in N+1.
// Backpressure: stall holds the head; when the buffer is full no request is issued.
// Ports: clk, rst, stall, redirect/redirect_pc, im_req/im_addr/im_ack/im_rdata,
//        id_valid/id_ins/id_pc_plus_4.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IM_AW      = 10,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic             im_ack,
    input  logic [31:0]      im_rdata,
    output logic             id_valid,
    output logic [31:0]      id_ins,
    output logic [31:0]      id_pc_plus_4
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic [31:0]   r_pend;

    logic [31:0]   w_tgt;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    entry_t        w_push_dat;
    entry_t        w_head;

    assign w_tgt       = redirect_pc & ~32'd3;
    assign id_valid    = (w_count != '0);
    assign w_pop       = id_valid && !stall && !redirect;
    assign w_push      = (r_state == S_REQ) && im_ack && !redirect;
    assign w_push_dat  = '{pc4: r_pc + 32'd4, ins: im_rdata};
    assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (redirect),
        .o_count    (w_count),
        .o_head     (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect) begin
                        if (im_ack) begin
                            r_pc <= w_tgt;
                        end else begin
                            // Request still in flight: remember target, discard its data later.
                            r_pend  <= w_tgt;
                            r_state <= S_DROP;
                        end
                    end else if (im_ack) begin
                        r_pc <= r_pc + 32'd4;
                        if (w_count_nxt == CW'(FIFO_DEPTH)) r_state <= S_FULL;
                    end
                end
                S_DROP: begin
                    if (im_ack) begin
                        // A redirect arriving with the ack is the newest target.
                        r_pc    <= redirect ? w_tgt : r_pend;
                        r_state <= S_REQ;
                    end else if (redirect) begin
                        r_pend <= w_tgt;
                    end
                end
                S_FULL: begin
                    if (redirect) begin
                        r_pc    <= w_tgt;
                        r_state <= S_REQ;
                    end else if (w_pop) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    assign im_req       = !rst && (r_state != S_FULL);
    assign im_addr      = r_pc[IM_AW+1:2];
    assign id_ins       = id_valid ? w_head.ins : NOP;
    assign id_pc_plus_4 = id_valid ? w_head.pc4 : 32'h0;

endmodule
